axi_sample_fifo_ctl: RTL and testbench

//  Bus-mapped, parametrised sample FIFO between sampler output and CPU bus; successor of the fixed 16-bit vendor-IP FIFO.
//  Own storage, generic width/depth; adds fill level, sticky overflow, saturating drop counter,

---
 rtl/sample_fifo_pkg.sv | 18 +
 rtl/axi_sample_fifo_ctl_if.sv | 12 +
 rtl/sample_fifo_ram.sv | 19 +
 rtl/axi_sample_fifo_ctl.sv | 100 ++++++++++
 tb/tb_axi_sample_fifo_ctl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sample_fifo_pkg.sv
// sample_fifo_pkg: register addresses, STATUS bit positions and bus FSM states for the sample FIFO
package sample_fifo_pkg;
  typedef enum logic {S_IDLE, S_RESP} bus_state_t;
  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_DATA = 2'd1;
  localparam logic [1:0] REG_POP = 2'd2;
  localparam logic [1:0] REG_LEVEL = 2'd3;
  localparam int ST_NEMPTY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF = 2;
  localparam int ST_THR = 3;
  localparam int ST_IRQEN = 4;
  localparam int WR_POP = 0;
  localparam int WR_CLR = 1;
  localparam int WR_FLUSH = 2;
  localparam int WR_IRQEN = 3;
  localparam int WR_IRQEN_VAL = 4;
endpackage

// File: rtl/axi_sample_fifo_ctl_if.sv
// axi_sample_fifo_ctl_if: CPU register bus (request avalid/awe/aaddr/adata, response aready/bvalid/bdata)
interface axi_sample_fifo_ctl_if;
  logic avalid;
  logic aready;
  logic awe;
  logic [3:2] aaddr;
  logic [31:0] adata;
  logic bvalid;
  logic [31:0] bdata;
  modport master(output avalid, awe, aaddr, adata, input aready, bvalid, bdata);
  modport slave(input avalid, awe, aaddr, adata, output aready, bvalid, bdata);
endinterface

// File: rtl/sample_fifo_ram.sv
// sample_fifo_ram: simple dual-port storage, sync write, registered read-first read
//   clk; we/waddr/wdata write port; raddr in, rdata registered out
module sample_fifo_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/axi_sample_fifo_ctl.sv
// axi_sample_fifo_ctl: bus-mapped sample FIFO with level, sticky overflow, drop counter, flush and threshold irq
//   clk, rst_n (sync, active-low); in_data/in_strobe sampler push; bus register slave;
//   irq = level>=THRESH && IRQ_EN (registered); overflow = sticky drop flag
module axi_sample_fifo_ctl
  import sample_fifo_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int DROP_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_strobe,
  axi_sample_fifo_ctl_if.slave   bus,
  output logic                   irq,
  output logic                   overflow
);
  localparam int LW = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] DEPTH = LW'(2**DEPTH_LOG2);
  bus_state_t state;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [LW-1:0] level, level_n, thresh, thresh_n;
  logic [DROP_W-1:0] drop, drop_n;
  logic [DATA_W-1:0] ram_q, byp_d, head;
  logic [31:0] status, rdata;
  logic irq_en, irq_en_n, ovf_n, byp_v;
  logic acc, st_wr, full, empty, flush, clr, do_pop, push_ok, drop_evt;
  logic unused_bits;
  assign unused_bits = ^bus.adata;
  assign bus.bvalid = state == S_RESP;
  assign bus.aready = bus.bvalid;
  always_comb begin
    acc = bus.bvalid && bus.avalid;
    st_wr = acc && bus.awe && bus.aaddr == REG_STATUS;
    full = level == DEPTH;
    empty = level == '0;
    flush = st_wr && bus.adata[WR_FLUSH];
    clr = st_wr && bus.adata[WR_CLR];
    do_pop = acc && !empty && !flush &&
             (bus.awe ? bus.aaddr == REG_STATUS && bus.adata[WR_POP] : bus.aaddr == REG_POP);
    // a pop on the same edge frees the slot, so a push into a full FIFO is then accepted
    push_ok = in_strobe && !flush && (!full || do_pop);
    drop_evt = in_strobe && !flush && full && !do_pop;
    wr_ptr_n = flush ? '0 : wr_ptr + DEPTH_LOG2'(push_ok);
    rd_ptr_n = flush ? '0 : rd_ptr + DEPTH_LOG2'(do_pop);
    level_n = flush ? '0 : level + LW'(push_ok) - LW'(do_pop);
    // a drop on the same edge as a clear wins: flag stays set and the counter restarts at 1
    ovf_n = drop_evt || (overflow && !clr);
    drop_n = drop_evt ? (clr ? DROP_W'(1) : (&drop ? drop : drop + DROP_W'(1))) : (clr ? '0 : drop);
    irq_en_n = st_wr && bus.adata[WR_IRQEN] ? bus.adata[WR_IRQEN_VAL] : irq_en;
    thresh_n = acc && bus.awe && bus.aaddr == REG_LEVEL ? bus.adata[LW-1:0] : thresh;
    // the RAM read port lags one edge; a write landing on the new head slot is forwarded
    head = byp_v ? byp_d : ram_q;
    status = '0;
    status[ST_NEMPTY] = !empty;
    status[ST_FULL] = full;
    status[ST_OVF] = overflow;
    status[ST_THR] = level >= thresh;
    status[ST_IRQEN] = irq_en;
    rdata = bus.aaddr == REG_STATUS ? status :
            bus.aaddr == REG_LEVEL ? (32'(drop) << 16) | 32'(level) :
            empty ? '0 : 32'(head);
    bus.bdata = bus.bvalid && !bus.awe ? rdata : '0;
  end
  always_ff @(posedge clk) begin
    byp_d <= in_data;
    if (!rst_n) begin
      state <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      thresh <= LW'(2**(DEPTH_LOG2-1));
      drop <= '0;
      overflow <= 1'b0;
      irq_en <= 1'b0;
      irq <= 1'b0;
      byp_v <= 1'b0;
    end else begin
      state <= state == S_IDLE && bus.avalid ? S_RESP : S_IDLE;
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      level <= level_n;
      thresh <= thresh_n;
      drop <= drop_n;
      overflow <= ovf_n;
      irq_en <= irq_en_n;
      irq <= irq_en_n && level_n >= thresh_n;
      byp_v <= push_ok && wr_ptr == rd_ptr_n;
    end
  end
  sample_fifo_ram #(.DATA_W(DATA_W), .ADDR_W(DEPTH_LOG2)) u_ram (
    .clk(clk),
    .we(rst_n && push_ok),
    .waddr(wr_ptr),
    .wdata(in_data),
    .raddr(rd_ptr_n),
    .rdata(ram_q)
  );
endmodule

// File: tb/tb_axi_sample_fifo_ctl.sv
// tb_axi_sample_fifo_ctl: randomized self-checking bench against a queue-based reference model
module tb_axi_sample_fifo_ctl;
  import sample_fifo_pkg::*;
  localparam int DW = 16;
  localparam int DL = 2;
  localparam int DRW = 3;
  localparam int DEPTH = 4;
  localparam int DMAX = 7;
  logic clk = 0;
  logic rst_n = 0;
  logic in_strobe = 0;
  logic [DW-1:0] in_data = 0;
  logic irq, overflow;
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] q[$];
  bit m_ovf, m_irqen, m_irq, m_resp;
  int m_drop, m_thresh;
  axi_sample_fifo_ctl_if bus();
  axi_sample_fifo_ctl #(.DATA_W(DW), .DEPTH_LOG2(DL), .DROP_W(DRW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_strobe(in_strobe),
    .bus(bus), .irq(irq), .overflow(overflow)
  );
  always #5 clk = ~clk;

  task automatic tick();
    bit acc, stw, popr, ovf_evt;
    if (!rst_n) begin
      q.delete();
      m_ovf = 0; m_irqen = 0; m_irq = 0; m_resp = 0; m_drop = 0; m_thresh = DEPTH / 2;
    end else begin
      acc = m_resp && bus.avalid;
      stw = acc && bus.awe && bus.aaddr == REG_STATUS;
      popr = acc && (bus.awe ? stw && bus.adata[0] : bus.aaddr == REG_POP);
      ovf_evt = 0;
      if (stw && bus.adata[2]) q.delete();
      else begin
        if (popr && q.size() > 0) void'(q.pop_front());
        if (in_strobe) begin
          if (q.size() < DEPTH) q.push_back(in_data);
          else ovf_evt = 1;
        end
      end
      if (stw && bus.adata[1]) begin m_ovf = 0; m_drop = 0; end
      if (ovf_evt) begin m_ovf = 1; m_drop = m_drop == DMAX ? DMAX : m_drop + 1; end
      if (stw && bus.adata[3]) m_irqen = bus.adata[4];
      if (acc && bus.awe && bus.aaddr == REG_LEVEL) m_thresh = int'(bus.adata[DL:0]);
      m_irq = m_irqen && q.size() >= m_thresh;
      m_resp = bus.avalid && !m_resp;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_rd(input bit we, input logic [1:0] a);
    if (we) return 32'h0;
    if (a == REG_STATUS)
      return {27'b0, m_irqen, q.size() >= m_thresh, m_ovf, q.size() == DEPTH, q.size() != 0};
    if (a == REG_LEVEL) return (32'(m_drop) << 16) | 32'(q.size());
    return q.size() != 0 ? 32'(q[0]) : 32'h0;
  endfunction

  task automatic xfer(input bit we, input logic [1:0] a, input logic [31:0] d, input bit sreq,
                      input bit sacc, output logic [31:0] rd, output logic [31:0] er, output logic bv);
    bus.avalid = 1; bus.awe = we; bus.aaddr = a; bus.adata = d;
    in_strobe = sreq; in_data = DW'($urandom);
    tick();
    bv = bus.bvalid; rd = bus.bdata; er = exp_rd(we, a);
    in_strobe = sacc; in_data = DW'($urandom);
    tick();
    bus.avalid = 0; bus.awe = 0; bus.adata = 0; in_strobe = 0;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] rd, output logic [31:0] er);
    logic bv;
    xfer(0, a, 0, 0, 0, rd, er, bv);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] rd, er;
    logic bv;
    xfer(1, a, d, 0, 0, rd, er, bv);
  endtask

  task automatic push(input logic [DW-1:0] v);
    in_strobe = 1; in_data = v;
    tick();
    in_strobe = 0;
  endtask

  task automatic test_reset();
    logic [31:0] rd, er;
    rst_n = 0; tick(); tick(); rst_n = 1; tick();
    checks++;
    if ({bus.bvalid, bus.aready, irq, overflow} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {bus.bvalid, bus.aready, irq, overflow});
    end
    checks++;
    if (bus.bdata !== 32'h0) begin errors++; $display("FAIL idle_bdata: got %h want 0", bus.bdata); end
    rd_reg(REG_LEVEL, rd, er);
    checks++;
    if (rd !== 32'h0 || rd !== er) begin errors++; $display("FAIL reset_level: got %h want 0", rd); end
    rd_reg(REG_STATUS, rd, er);
    checks++;
    if (rd !== 32'h0 || rd !== er) begin errors++; $display("FAIL reset_status: got %h want 0", rd); end
  endtask

  task automatic test_basic();
    logic [31:0] rd, er;
    logic [15:0] v[3] = '{16'h1111, 16'h2222, 16'h3333};
    for (int i = 0; i < 3; i++) push(v[i]);
    rd_reg(REG_LEVEL, rd, er);
    checks++;
    if (rd !== 32'd3 || rd !== er) begin errors++; $display("FAIL basic_level: got %h want 3", rd); end
    for (int i = 0; i < 3; i++) begin
      rd_reg(REG_POP, rd, er);
      checks++;
      if (rd !== 32'(v[i]) || rd !== er) begin
        errors++; $display("FAIL basic_pop%0d: got %h want %h", i, rd, v[i]);
      end
    end
    rd_reg(REG_STATUS, rd, er);
    checks++;
    if (rd[0] !== 1'b0 || rd !== er) begin errors++; $display("FAIL basic_empty: got %h want %h", rd, er); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd, er;
    for (int i = 0; i < 6; i++) push(DW'($urandom));
    rd_reg(REG_LEVEL, rd, er);
    checks++;
    if (rd !== 32'h0002_0004 || rd !== er) begin errors++; $display("FAIL ovf_level: got %h want 00020004", rd); end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    wr_reg(REG_STATUS, 32'h2);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    rd_reg(REG_LEVEL, rd, er);
    checks++;
    if (rd !== 32'h4 || rd !== er) begin errors++; $display("FAIL ovf_clr_level: got %h want 4", rd); end
    for (int i = 0; i < 4; i++) begin
      rd_reg(REG_POP, rd, er);
      checks++;
      if (rd !== er) begin errors++; $display("FAIL ovf_data%0d: got %h want %h", i, rd, er); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd, er;
    logic bv;
    for (int i = 0; i < 4; i++) push(DW'($urandom));
    for (int i = 0; i < 6; i++) begin
      xfer(0, REG_POP, 0, 0, 1, rd, er, bv);
      checks++;
      if (rd !== er) begin errors++; $display("FAIL wrap_pp%0d: got %h want %h", i, rd, er); end
    end
    rd_reg(REG_LEVEL, rd, er);
    checks++;
    if (rd !== 32'h4 || overflow !== 1'b0) begin
      errors++; $display("FAIL wrap_level: got %h/%b want 4/0", rd, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      rd_reg(REG_POP, rd, er);
      checks++;
      if (rd !== er) begin errors++; $display("FAIL wrap_drain%0d: got %h want %h", i, rd, er); end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] rd, er;
    logic bv;
    xfer(0, REG_DATA, 0, 1, 0, rd, er, bv);
    checks++;
    if (bv !== 1'b1 || rd !== er) begin errors++; $display("FAIL bypass: got %h want %h", rd, er); end
    rd_reg(REG_POP, rd, er);
    rd_reg(REG_POP, rd, er);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL pop_empty: got %h want 0", rd); end
    rd_reg(REG_LEVEL, rd, er);
    checks++;
    if (rd !== 32'h0 || rd !== er) begin errors++; $display("FAIL empty_level: got %h want 0", rd); end
  endtask

  task automatic test_irq();
    logic [31:0] rd, er;
    logic bv;
    wr_reg(REG_LEVEL, 32'd2);
    wr_reg(REG_STATUS, 32'h18);
    push(DW'($urandom));
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_lvl1: got %b want 0", irq); end
    push(DW'($urandom));
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_lvl2: got %b want 1", irq); end
    rd_reg(REG_POP, rd, er);
    checks++;
    if (irq !== 1'b0 || rd !== er) begin errors++; $display("FAIL irq_pop: got %b/%h want 0/%h", irq, rd, er); end
    push(DW'($urandom));
    xfer(1, REG_STATUS, 32'h4, 0, 1, rd, er, bv);
    rd_reg(REG_LEVEL, rd, er);
    checks++;
    if (rd !== 32'h0 || irq !== 1'b0) begin
      errors++; $display("FAIL flush_push: got %h/%b want 0/0", rd, irq);
    end
    wr_reg(REG_LEVEL, 32'd0);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_thresh0: got %b want 1", irq); end
    wr_reg(REG_STATUS, 32'h08);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_disable: got %b want 0", irq); end
  endtask

  task automatic test_saturate();
    logic [31:0] rd, er;
    logic bv;
    wr_reg(REG_STATUS, 32'h2);
    for (int i = 0; i < 14; i++) push(DW'($urandom));
    rd_reg(REG_LEVEL, rd, er);
    checks++;
    if (rd !== 32'h0007_0004 || rd !== er) begin errors++; $display("FAIL drop_sat: got %h want 00070004", rd); end
    xfer(1, REG_STATUS, 32'h2, 0, 1, rd, er, bv);
    rd_reg(REG_LEVEL, rd, er);
    checks++;
    if (rd !== 32'h0001_0004 || overflow !== 1'b1) begin
      errors++; $display("FAIL clr_vs_set: got %h/%b want 00010004/1", rd, overflow);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, er;
    logic bv;
    for (int i = 0; i < 150; i++) begin
      int op;
      int n;
      op = $urandom_range(0, 3);
      n = $urandom_range(0, 2);
      repeat (n) begin
        in_strobe = 1'($urandom_range(0, 1)); in_data = DW'($urandom);
        tick();
      end
      in_strobe = 0;
      case (op)
        0: xfer(0, 2'($urandom_range(0, 3)), 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd, er, bv);
        1: xfer(1, REG_STATUS, $urandom & 32'h1f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd, er, bv);
        2: xfer(1, REG_LEVEL, 32'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd, er, bv);
        default: xfer(0, REG_POP, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd, er, bv);
      endcase
      checks++;
      if ({rd, irq, overflow} !== {er, m_irq, m_ovf}) begin
        errors++; $display("FAIL random%0d: got %h/%b/%b want %h/%b/%b", i, rd, irq, overflow, er, m_irq, m_ovf);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, er;
    wr_reg(REG_LEVEL, 32'd3);
    push(DW'($urandom));
    push(DW'($urandom));
    bus.avalid = 1; bus.awe = 0; bus.aaddr = REG_POP;
    tick();
    checks++;
    if (bus.bvalid !== 1'b1) begin errors++; $display("FAIL mid_bvalid: got %b want 1", bus.bvalid); end
    rst_n = 0;
    tick();
    rst_n = 1; bus.avalid = 0;
    checks++;
    if ({bus.bvalid, irq, overflow} !== 3'b0) begin
      errors++; $display("FAIL mid_reset: got %b want 000", {bus.bvalid, irq, overflow});
    end
    tick();
    push(DW'($urandom));
    push(DW'($urandom));
    rd_reg(REG_STATUS, rd, er);
    checks++;
    if (rd !== 32'h09 || rd !== er) begin errors++; $display("FAIL mid_thresh: got %h want 00000009", rd); end
  endtask

  initial begin
    bus.avalid = 0; bus.awe = 0; bus.aaddr = 0; bus.adata = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_wrap();
    test_bypass();
    test_irq();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
